clock_out_ctrl: RTL

CLOCK_OUT_CTRL -- requirements
Module: clock_out_ctrl

---
 rtl/clock_out_ctrl_pkg.sv | 18 +
 rtl/clock_out_ctrl_if.sv | 37 +++
 rtl/clock_out_phase_cnt.sv | 27 ++
 rtl/clock_out_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/clock_out_ctrl_pkg.sv
// Shared types and constants for the clock_out_ctrl divided-clock generator.
// Optional burst mode is enabled by defining CLOCK_OUT_CTRL_BURST_EN.
package clock_out_ctrl_pkg;

    localparam int HALF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    // A requested half-period of 0 behaves as 1.
    function automatic logic [HALF_W-1:0] eff_half(input logic [HALF_W-1:0] h);
        return (h == '0) ? HALF_W'(1) : h;
    endfunction

endpackage

// File: rtl/clock_out_ctrl_if.sv
// Control, config handshake and output bundle of clock_out_ctrl.
// burst_len/burst_done exist only when CLOCK_OUT_CTRL_BURST_EN is defined.
interface clock_out_ctrl_if;
    import clock_out_ctrl_pkg::*;

    logic              start;
    logic              stop;
    logic              cfg_valid;
    logic [HALF_W-1:0] cfg_half;
    logic              cfg_ready;
    logic              clock_out;
    logic              running;
    logic              edge_strobe;
`ifdef CLOCK_OUT_CTRL_BURST_EN
    logic [HALF_W-1:0] burst_len;
    logic              burst_done;

    modport master (
        output start, stop, cfg_valid, cfg_half, burst_len,
        input  cfg_ready, clock_out, running, edge_strobe, burst_done
    );
    modport slave (
        input  start, stop, cfg_valid, cfg_half, burst_len,
        output cfg_ready, clock_out, running, edge_strobe, burst_done
    );
`else
    modport master (
        output start, stop, cfg_valid, cfg_half,
        input  cfg_ready, clock_out, running, edge_strobe
    );
    modport slave (
        input  start, stop, cfg_valid, cfg_half,
        output cfg_ready, clock_out, running, edge_strobe
    );
`endif

endinterface

// File: rtl/clock_out_phase_cnt.sv
// Loadable 8-bit phase down-counter; saturates at zero and flags expiry.
module clock_out_phase_cnt
    import clock_out_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [HALF_W-1:0] load_val,
    input  logic              dec,
    output logic              expired
);

    logic [HALF_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - HALF_W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/clock_out_ctrl.sv
// Glitch-free programmable divided-clock generator with start/stop control.
// Define CLOCK_OUT_CTRL_BURST_EN to add burst_len/burst_done (auto-stop after N edges).
//
// state       | meaning
// ST_IDLE     | clock_out held 0; waits for start, config applies next cycle
// ST_RUN      | clock_out toggles every H cycles; config held pending to next toggle
// ST_STOPPING | finishing current period; returns to IDLE where next rise would be
module clock_out_ctrl
    import clock_out_ctrl_pkg::*;
#(
    parameter int DEFAULT_HALF = 1
) (
    input  logic             clock,
    input  logic             reset,
    clock_out_ctrl_if.slave  bus
);

    state_t            state_q, state_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              clk_out_q, clk_out_d;
    logic              strobe_q, strobe_d;

    logic              cnt_load;
    logic [HALF_W-1:0] cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    logic              cfg_xfer;
    logic [HALF_W-1:0] half_in;

`ifdef CLOCK_OUT_CTRL_BURST_EN
    logic              burst_on_q, burst_on_d;
    logic [HALF_W-1:0] burst_rem_q, burst_rem_d;
    logic              burst_done_q, burst_done_d;
`endif

    assign cfg_xfer = bus.cfg_valid & ~pend_vld_q;
    assign half_in  = eff_half(bus.cfg_half);

    clock_out_phase_cnt u_phase_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .expired  (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        clk_out_d    = clk_out_q;
        strobe_d     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = half_q - HALF_W'(1);
        cnt_dec      = 1'b0;
`ifdef CLOCK_OUT_CTRL_BURST_EN
        burst_on_d   = burst_on_q;
        burst_rem_d  = burst_rem_q;
        burst_done_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                clk_out_d = 1'b0;
                if (cfg_xfer) begin
                    half_d = half_in;
                end
                if (bus.start && !bus.stop) begin
                    state_d   = ST_RUN;
                    clk_out_d = 1'b1;
                    strobe_d  = 1'b1;
                    cnt_load  = 1'b1;
`ifdef CLOCK_OUT_CTRL_BURST_EN
                    // burst_rem counts edges still owed after this first one
                    burst_on_d  = (bus.burst_len != '0);
                    burst_rem_d = bus.burst_len - HALF_W'(1);
`endif
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (cfg_xfer) begin
                    pend_d     = half_in;
                    pend_vld_d = 1'b1;
                end
                if ((state_q == ST_RUN) && bus.stop) begin
                    state_d = ST_STOPPING;
                end
`ifdef CLOCK_OUT_CTRL_BURST_EN
                if ((state_q == ST_RUN) && burst_on_q && (burst_rem_q == '0)) begin
                    state_d = ST_STOPPING;
                end
`endif
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if ((state_q == ST_STOPPING) && !clk_out_q) begin
                    // suppress the rising edge; a stranded pending config lands here
                    state_d = ST_IDLE;
                    if (pend_vld_q) begin
                        half_d     = pend_q;
                        pend_vld_d = 1'b0;
                    end
`ifdef CLOCK_OUT_CTRL_BURST_EN
                    burst_done_d = burst_on_q;
                    burst_on_d   = 1'b0;
`endif
                end else begin
                    clk_out_d = ~clk_out_q;
                    strobe_d  = ~clk_out_q;
                    cnt_load  = 1'b1;
                    if (pend_vld_q) begin
                        half_d       = pend_q;
                        pend_vld_d   = 1'b0;
                        cnt_load_val = pend_q - HALF_W'(1);
                    end
`ifdef CLOCK_OUT_CTRL_BURST_EN
                    if (!clk_out_q && (state_q == ST_RUN) && (burst_rem_q != '0)) begin
                        burst_rem_d = burst_rem_q - HALF_W'(1);
                    end
`endif
                end
            end

            default: begin
                state_d   = ST_IDLE;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            half_q     <= HALF_W'(DEFAULT_HALF);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            strobe_q   <= strobe_d;
        end
    end

`ifdef CLOCK_OUT_CTRL_BURST_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            burst_on_q   <= 1'b0;
            burst_rem_q  <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_on_q   <= burst_on_d;
            burst_rem_q  <= burst_rem_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign bus.burst_done = burst_done_q;
`endif

    assign bus.clock_out   = clk_out_q;
    assign bus.running     = (state_q != ST_IDLE);
    assign bus.edge_strobe = strobe_q;
    assign bus.cfg_ready   = ~pend_vld_q;

endmodule
